wb_stage_p: RTL and testbench
=============================

WB_STAGE_P -- requirements
Module: wb_stage_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count; AW = clog2(NREG).
REQ-003 SHALL have parameter ECODE_W, default 6, meaning exception code width.
REQ-004 SHALL have parameter CNT_W, default 32, meaning retire counter width.
REQ-005 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: mem_valid  in  1  MEM has an instruction; wb_allowin  out  1  WB can accept.
REQ-007 SHALL have ports: mem_pc  in  XLEN; mem_rf_we  in  1; mem_rf_waddr  in  AW; mem_rf_wdata  in  XLEN.
REQ-008 SHALL have ports: mem_exc  in  1  exception flag; mem_ecode  in  ECODE_W; mem_ertn  in  1  exception-return flag.
REQ-009 SHALL have ports: wb_stall  in  1  external hold, e.g. CSR busy.
REQ-010 SHALL have ports: rf_we  out  1; rf_waddr  out  AW; rf_wdata  out  XLEN  regfile write and ID bypass.
REQ-011 SHALL have ports: wb_flush  out  1; exc_commit  out  1; ertn_commit  out  1; exc_ecode  out  ECODE_W; exc_pc  out  XLEN.
REQ-012 SHALL have ports: retire_cnt  out  CNT_W.
REQ-013 SHALL have ports: debug_wb_pc  out  XLEN; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  AW; debug_wb_rf_wdata  out  XLEN.

Function
REQ-014 SHALL define wb_ready_go = ~wb_stall and wb_allowin = ~wb_valid | wb_ready_go.
REQ-015 SHALL define leave = wb_valid & wb_ready_go; instruction retires from WB in the leave cycle.
REQ-016 SHALL accept an instruction on the cycle mem_valid & wb_allowin & ~wb_flush; the next-cycle wb_valid shall then be 1.
REQ-017 SHALL clear wb_valid after leave when there is no accept; hold wb_valid and the payload while stalled.
REQ-018 SHALL load payload registers (pc, we, waddr, wdata, exc, ecode, ertn) only on accept; they are never overwritten while holding.
REQ-019 SHALL drive rf_we = leave & we & ~exc & ~ertn & (waddr != 0); rf_waddr and rf_wdata come from the registers (combinational, zero added latency).
REQ-020 SHALL assert exc_commit = leave & exc and ertn_commit = leave & ertn & ~exc, each for exactly one cycle per instruction.
REQ-021 SHALL assert wb_flush = exc_commit | ertn_commit; exc_ecode = registered ecode; exc_pc = registered pc.
REQ-022 SHALL discard the MEM instruction presented during a wb_flush cycle (no accept) even though wb_allowin = 1.
REQ-023 SHALL increment retire_cnt by 1 on leave & ~exc; it shall wrap from 2^CNT_W-1 to 0.
REQ-024 SHALL drive debug_wb_pc = registered pc, debug_wb_rf_we = {4{rf_we}}, wnum/wdata = rf_waddr/rf_wdata.
REQ-025 SHALL keep exc taking priority over ertn when both are set.
REQ-026 SHALL give wb_stall and a waiting instruction no effect when wb_valid = 0 (bubble passes, allowin = 1).

Reset
REQ-027 SHALL, when resetn = 0 at posedge clk, clear wb_valid, retire_cnt, and all payload registers to 0.
REQ-028 SHALL therefore hold all outputs at 0 during reset, with wb_allowin = 1.
REQ-029 SHALL, on reset mid-stall, drop the held instruction with no commit and no regfile write.

Structure
REQ-030 SHALL place the ECODE constants and the MEM->WB payload struct typedef in shared package wb_pkg.
REQ-031 SHALL instantiate the retire counter as sub-module perf_counter (parameter CNT_W, inputs inc and clear).

Verification
REQ-032 SHALL cover back-to-back retire: pc 0x1C000000/04/08 with we = 1, waddr = 5/6/7 -> three consecutive rf_we pulses, retire_cnt = 3.
REQ-033 SHALL cover r0 write: waddr = 0, we = 1, wdata = 0xDEADBEEF -> rf_we = 0, debug_wb_rf_we = 0, retire_cnt += 1.
REQ-034 SHALL cover stall: wb_stall = 1 for 3 cycles with a valid instruction -> wb_allowin = 0, payload stable, a single rf_we pulse after release.
REQ-035 SHALL cover exception: exc = 1, ecode = 0x0B, pc = 0x1C000010, next MEM instruction valid -> one-cycle wb_flush/exc_commit, exc_pc = 0x1C000010, no rf_we, next instruction dropped, counter unchanged.
REQ-036 SHALL cover counter wrap: CNT_W = 4, 17 retires -> retire_cnt = 1.
REQ-037 SHALL cover reset during stall: resetn = 0 -> wb_valid = 0, no commit pulse, retire_cnt = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared exception codes and the MEM->WB payload type.
// Payload fields are sized for the widest supported configuration (XLEN<=64, NREG<=256, ECODE_W<=16).
package wb_pkg;
    localparam int PL_XLEN    = 64;
    localparam int PL_AW      = 8;
    localparam int PL_ECODE_W = 16;
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    typedef struct packed {
        logic [PL_XLEN-1:0]    pc;
        logic                  we;
        logic [PL_AW-1:0]      waddr;
        logic [PL_XLEN-1:0]    wdata;
        logic                  exc;
        logic [PL_ECODE_W-1:0] ecode;
        logic                  ertn;
    } wb_payload_t;
endpackage

// File: rtl/wb_stage_p_perf_counter.sv
// perf_counter: wrapping event counter with synchronous clear.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : cnt_q + CNT_W'(inc);
    always_ff @(posedge clk) cnt_q <= !resetn ? '0 : cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/wb_stage_p.sv
// wb_stage_p: pipeline write-back stage; commits regfile writes, exceptions and ertn,
// and counts retired instructions.
module wb_stage_p
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int ECODE_W = 6,
    parameter int CNT_W   = 32,
    localparam int AW     = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               mem_valid,
    output logic               wb_allowin,
    input  logic [XLEN-1:0]    mem_pc,
    input  logic               mem_rf_we,
    input  logic [AW-1:0]      mem_rf_waddr,
    input  logic [XLEN-1:0]    mem_rf_wdata,
    input  logic               mem_exc,
    input  logic [ECODE_W-1:0] mem_ecode,
    input  logic               mem_ertn,
    input  logic               wb_stall,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               wb_flush,
    output logic               exc_commit,
    output logic               ertn_commit,
    output logic [ECODE_W-1:0] exc_ecode,
    output logic [XLEN-1:0]    exc_pc,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [XLEN-1:0]    debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [AW-1:0]      debug_wb_rf_wnum,
    output logic [XLEN-1:0]    debug_wb_rf_wdata
);
    logic        wb_valid_q, wb_valid_d;
    wb_payload_t p_q, p_d;
    logic        wb_ready_go, leave, accept, unused_hi;

    assign wb_ready_go = ~wb_stall;
    assign wb_allowin  = ~wb_valid_q | wb_ready_go;
    // Gating with resetn keeps a held instruction from committing in the reset cycle.
    assign leave       = wb_valid_q & wb_ready_go & resetn;
    assign accept      = mem_valid & wb_allowin & ~wb_flush;

    always_comb begin
        wb_valid_d = accept ? 1'b1 : (leave ? 1'b0 : wb_valid_q);
        p_d        = p_q;
        if (accept) begin
            p_d.pc    = PL_XLEN'(mem_pc);
            p_d.we    = mem_rf_we;
            p_d.waddr = PL_AW'(mem_rf_waddr);
            p_d.wdata = PL_XLEN'(mem_rf_wdata);
            p_d.exc   = mem_exc;
            p_d.ecode = PL_ECODE_W'(mem_ecode);
            p_d.ertn  = mem_ertn;
        end
    end

    always_ff @(posedge clk) begin
        wb_valid_q <= resetn ? wb_valid_d : 1'b0;
        p_q        <= resetn ? p_d : '0;
    end

    assign rf_we       = leave & p_q.we & ~p_q.exc & ~p_q.ertn & (p_q.waddr != '0);
    assign rf_waddr    = p_q.waddr[AW-1:0];
    assign rf_wdata    = p_q.wdata[XLEN-1:0];
    assign exc_commit  = leave & p_q.exc;
    assign ertn_commit = leave & p_q.ertn & ~p_q.exc;
    assign wb_flush    = exc_commit | ertn_commit;
    assign exc_ecode   = p_q.ecode[ECODE_W-1:0];
    assign exc_pc      = p_q.pc[XLEN-1:0];

    assign debug_wb_pc       = p_q.pc[XLEN-1:0];
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign unused_hi = ^{p_q.pc >> XLEN, p_q.wdata >> XLEN, p_q.waddr >> AW, p_q.ecode >> ECODE_W};

    perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .resetn(resetn),
        .inc   (leave & ~p_q.exc),
        .clear (1'b0),
        .cnt   (retire_cnt)
    );
endmodule

// File: tb/tb_wb_stage_p.sv
// tb_wb_stage_p: directed scenario tests for wb_stage_p (CNT_W=4 so wrap is reachable).
module tb_wb_stage_p;
    logic        clk, resetn, mem_valid, wb_allowin, mem_rf_we, mem_exc, mem_ertn, wb_stall;
    logic [31:0] mem_pc, mem_rf_wdata, rf_wdata, exc_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic [4:0]  mem_rf_waddr, rf_waddr, debug_wb_rf_wnum;
    logic [5:0]  mem_ecode, exc_ecode;
    logic        rf_we, wb_flush, exc_commit, ertn_commit;
    logic [3:0]  retire_cnt, debug_wb_rf_we;
    int          errors = 0, checks = 0;

    wb_stage_p #(.XLEN(32), .NREG(32), .ECODE_W(6), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
        .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr), .mem_rf_wdata(mem_rf_wdata),
        .mem_exc(mem_exc), .mem_ecode(mem_ecode), .mem_ertn(mem_ertn), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_flush(wb_flush),
        .exc_commit(exc_commit), .ertn_commit(ertn_commit), .exc_ecode(exc_ecode), .exc_pc(exc_pc),
        .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic exc, input logic [5:0] ec, input logic ertn);
        mem_valid = 1'b1; mem_pc = pc; mem_rf_we = we; mem_rf_waddr = wa; mem_rf_wdata = wd;
        mem_exc = exc; mem_ecode = ec; mem_ertn = ertn;
    endtask

    task automatic test_reset;
        resetn = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
        present(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 1'b0); mem_valid = 1'b0;
        tick; tick;
        checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got=%0b exp=1", wb_allowin); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got=%0b exp=0", rf_we); end
        checks++; if (retire_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", retire_cnt); end
        checks++; if (wb_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b exp=0", wb_flush); end
        checks++; if (debug_wb_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", debug_wb_pc); end
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back;
        present(32'h1C000000, 1'b1, 5'd5, 32'hA0, 1'b0, 6'h0, 1'b0);
        tick; present(32'h1C000004, 1'b1, 5'd6, 32'hA1, 1'b0, 6'h0, 1'b0); #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hA0) begin errors++; $display("FAIL b2b_0 got=%0b/%0d/%h exp=1/5/a0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (debug_wb_pc !== 32'h1C000000 || debug_wb_rf_we !== 4'hF) begin errors++; $display("FAIL b2b_dbg0 got=%h/%h exp=1c000000/f", debug_wb_pc, debug_wb_rf_we); end
        tick; present(32'h1C000008, 1'b1, 5'd7, 32'hA2, 1'b0, 6'h0, 1'b0); #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6) begin errors++; $display("FAIL b2b_1 got=%0b/%0d exp=1/6", rf_we, rf_waddr); end
        tick; mem_valid = 1'b0; #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || debug_wb_pc !== 32'h1C000008) begin errors++; $display("FAIL b2b_2 got=%0b/%0d/%h exp=1/7/1c000008", rf_we, rf_waddr, debug_wb_pc); end
        tick;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0b exp=0", rf_we); end
        checks++; if (retire_cnt !== 4'd3) begin errors++; $display("FAIL b2b_cnt got=%0d exp=3", retire_cnt); end
    endtask

    task automatic test_r0_write;
        present(32'h1C00000C, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 6'h0, 1'b0);
        tick; mem_valid = 1'b0; #1;
        checks++; if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0) begin errors++; $display("FAIL r0_we got=%0b/%h exp=0/0", rf_we, debug_wb_rf_we); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL r0_wdata got=%h exp=deadbeef", rf_wdata); end
        tick;
        checks++; if (retire_cnt !== 4'd4) begin errors++; $display("FAIL r0_cnt got=%0d exp=4", retire_cnt); end
    endtask

    task automatic test_stall;
        present(32'h1C000020, 1'b1, 5'd9, 32'h1234, 1'b0, 6'h0, 1'b0);
        tick; wb_stall = 1'b1; present(32'h1C000024, 1'b1, 5'd10, 32'h5678, 1'b0, 6'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (wb_allowin !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got=%0b/%0b exp=0/0", i, wb_allowin, rf_we); end
            checks++; if (debug_wb_pc !== 32'h1C000020 || rf_wdata !== 32'h1234) begin errors++; $display("FAIL stall_payload%0d got=%h/%h exp=1c000020/1234", i, debug_wb_pc, rf_wdata); end
            tick;
        end
        wb_stall = 1'b0; #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || wb_allowin !== 1'b1) begin errors++; $display("FAIL stall_release got=%0b/%0d/%0b exp=1/9/1", rf_we, rf_waddr, wb_allowin); end
        tick; mem_valid = 1'b0; #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10) begin errors++; $display("FAIL stall_next got=%0b/%0d exp=1/10", rf_we, rf_waddr); end
        tick;
        checks++; if (rf_we !== 1'b0 || retire_cnt !== 4'd6) begin errors++; $display("FAIL stall_end got=%0b/%0d exp=0/6", rf_we, retire_cnt); end
    endtask

    task automatic test_exception;
        present(32'h1C000010, 1'b1, 5'd3, 32'h77, 1'b1, 6'h0B, 1'b0);
        tick; present(32'h1C000014, 1'b1, 5'd4, 32'h55, 1'b0, 6'h0, 1'b0); #1;
        checks++; if (wb_flush !== 1'b1 || exc_commit !== 1'b1 || ertn_commit !== 1'b0) begin errors++; $display("FAIL exc_pulse got=%0b/%0b/%0b exp=1/1/0", wb_flush, exc_commit, ertn_commit); end
        checks++; if (exc_ecode !== 6'h0B || exc_pc !== 32'h1C000010) begin errors++; $display("FAIL exc_info got=%h/%h exp=0b/1c000010", exc_ecode, exc_pc); end
        checks++; if (rf_we !== 1'b0 || wb_allowin !== 1'b1) begin errors++; $display("FAIL exc_we got=%0b/%0b exp=0/1", rf_we, wb_allowin); end
        tick; mem_valid = 1'b0; #1;
        checks++; if (wb_flush !== 1'b0 || exc_commit !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL exc_after got=%0b/%0b/%0b exp=0/0/0", wb_flush, exc_commit, rf_we); end
        checks++; if (debug_wb_pc !== 32'h1C000010) begin errors++; $display("FAIL exc_drop got=%h exp=1c000010", debug_wb_pc); end
        checks++; if (retire_cnt !== 4'd6) begin errors++; $display("FAIL exc_cnt got=%0d exp=6", retire_cnt); end
    endtask

    task automatic test_ertn;
        present(32'h1C000030, 1'b1, 5'd2, 32'h99, 1'b0, 6'h0, 1'b1);
        tick; mem_valid = 1'b0; #1;
        checks++; if (ertn_commit !== 1'b1 || exc_commit !== 1'b0 || wb_flush !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL ertn got=%0b/%0b/%0b/%0b exp=1/0/1/0", ertn_commit, exc_commit, wb_flush, rf_we); end
        tick; present(32'h1C000034, 1'b1, 5'd2, 32'h99, 1'b1, 6'h0C, 1'b1);
        tick; mem_valid = 1'b0; #1;
        checks++; if (exc_commit !== 1'b1 || ertn_commit !== 1'b0 || exc_ecode !== 6'h0C) begin errors++; $display("FAIL exc_prio got=%0b/%0b/%h exp=1/0/0c", exc_commit, ertn_commit, exc_ecode); end
        tick;
        checks++; if (retire_cnt !== 4'd7) begin errors++; $display("FAIL ertn_cnt got=%0d exp=7", retire_cnt); end
    endtask

    task automatic test_wrap;
        resetn = 1'b0; tick; resetn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            present(32'h1C000100 + 32'(i * 4), 1'b1, 5'(i % 31 + 1), 32'(i), 1'b0, 6'h0, 1'b0);
            tick;
        end
        mem_valid = 1'b0; #1;
        checks++; if (retire_cnt !== 4'd0) begin errors++; $display("FAIL wrap16 got=%0d exp=0", retire_cnt); end
        tick;
        checks++; if (retire_cnt !== 4'd1) begin errors++; $display("FAIL wrap17 got=%0d exp=1", retire_cnt); end
    endtask

    task automatic test_reset_in_stall;
        present(32'h1C000040, 1'b1, 5'd8, 32'h42, 1'b1, 6'h0B, 1'b0);
        tick; wb_stall = 1'b1; mem_valid = 1'b0; #1;
        checks++; if (wb_allowin !== 1'b0 || exc_commit !== 1'b0) begin errors++; $display("FAIL rs_hold got=%0b/%0b exp=0/0", wb_allowin, exc_commit); end
        tick; resetn = 1'b0; wb_stall = 1'b0; #1;
        checks++; if (exc_commit !== 1'b0 || wb_flush !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL rs_commit got=%0b/%0b/%0b exp=0/0/0", exc_commit, wb_flush, rf_we); end
        tick; wb_stall = 1'b1; #1;
        checks++; if (wb_allowin !== 1'b1 || retire_cnt !== 4'd0 || exc_pc !== 32'h0) begin errors++; $display("FAIL rs_clear got=%0b/%0d/%h exp=1/0/0", wb_allowin, retire_cnt, exc_pc); end
        resetn = 1'b1; wb_stall = 1'b0;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_r0_write;
        test_stall;
        test_exception;
        test_ertn;
        test_wrap;
        test_reset_in_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
